// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encoding and checker state encoding.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OPC_W  = 3;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_PASS = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU; carry and overflow are dropped.
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int OPC_W = alu_pkg::OPC_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPC_W-1:0]  op_code,
   output logic [DATA_W-1:0] exp_out
);

   always_comb begin
      exp_out = a;
      case (op_code)
         OPC_W'(OP_ADD):  exp_out = a + b;
         OPC_W'(OP_SUB):  exp_out = a - b;
         OPC_W'(OP_AND):  exp_out = a & b;
         OPC_W'(OP_OR):   exp_out = a | b;
         OPC_W'(OP_XOR):  exp_out = a ^ b;
         OPC_W'(OP_SHL):  exp_out = {a[DATA_W-2:0], 1'b0};
         OPC_W'(OP_SHR):  exp_out = {1'b0, a[DATA_W-1:1]};
         default:         exp_out = a;
      endcase
   end

endmodule

// File: rtl/alu_result_checker.sv
// Checks a stream of ALU transactions against the reference model and keeps run statistics.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting transactions until txn_target have been taken
// ST_DRAIN | last accepted transaction is being compared
// ST_DONE  | run complete, results held until next start
module alu_result_checker
   import alu_pkg::*;
#(
   parameter int TXN_W = 8,
   parameter int OPC_W = alu_pkg::OPC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TXN_W-1:0]  txn_target,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPC_W-1:0]  op_code,
   input  logic [DATA_W-1:0] alu_out,
   output logic              mismatch,
   output logic [TXN_W-1:0]  pass_cnt,
   output logic [TXN_W-1:0]  fail_cnt,
   output logic [OPC_W-1:0]  first_fail_op,
   output logic [DATA_W-1:0] first_fail_exp,
   output logic [DATA_W-1:0] first_fail_got,
   output logic              done,
   output logic              all_pass
);

   chk_state_e        state;
   chk_state_e        state_nxt;
   logic              accept;
   logic              last_accept;
   logic [TXN_W-1:0]  remaining;
   logic              cmp_valid;
   logic              cmp_fail;
   logic [DATA_W-1:0] cmp_exp;
   logic [DATA_W-1:0] cmp_got;
   logic [OPC_W-1:0]  cmp_op;
   logic [DATA_W-1:0] ref_exp;

   alu_ref_model #(
      .OPC_W   (OPC_W)
   ) u_ref (
      .a       (a),
      .b       (b),
      .op_code (op_code),
      .exp_out (ref_exp)
   );

   assign accept      = in_ready && in_valid;
   assign last_accept = accept && (remaining == TXN_W'(1));
   assign cmp_fail    = cmp_valid && (cmp_exp != cmp_got);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = (txn_target == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (state)
            ST_RUN:   if (last_accept) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == ST_RUN);
      done     = (state == ST_DONE);
      all_pass = (state == ST_DONE) && (fail_cnt == '0);
      mismatch = cmp_fail;
   end

   // Remaining-transaction down-counter plus the single-stage compare register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         cmp_valid <= 1'b0;
         cmp_exp   <= '0;
         cmp_got   <= '0;
         cmp_op    <= '0;
      end else if (start) begin
         remaining <= txn_target;
         cmp_valid <= 1'b0;
      end else begin
         cmp_valid <= accept;
         if (accept) begin
            remaining <= remaining - TXN_W'(1);
            cmp_exp   <= ref_exp;
            cmp_got   <= alu_out;
            cmp_op    <= op_code;
         end
      end
   end

   // Saturating run counters; a zero fail count marks the first failure of the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         first_fail_op  <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else if (start) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         first_fail_op  <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else if (cmp_valid) begin
         if (cmp_fail) begin
            if (fail_cnt == '0) begin
               first_fail_op  <= cmp_op;
               first_fail_exp <= cmp_exp;
               first_fail_got <= cmp_got;
            end
            if (fail_cnt != '1) fail_cnt <= fail_cnt + TXN_W'(1);
         end else if (pass_cnt != '1) begin
            pass_cnt <= pass_cnt + TXN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker with hand-computed expectations.
module tb_alu_result_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] txn_target = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] op_code = '0;
   logic [7:0] alu_out = '0;
   logic       mismatch;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [2:0] first_fail_op;
   logic [7:0] first_fail_exp;
   logic [7:0] first_fail_got;
   logic       done;
   logic       all_pass;

   int n_checks = 0;
   int n_errors = 0;

   alu_result_checker #(
      .TXN_W          (8),
      .OPC_W          (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .txn_target     (txn_target),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .a              (a),
      .b              (b),
      .op_code        (op_code),
      .alu_out        (alu_out),
      .mismatch       (mismatch),
      .pass_cnt       (pass_cnt),
      .fail_cnt       (fail_cnt),
      .first_fail_op  (first_fail_op),
      .first_fail_exp (first_fail_exp),
      .first_fail_got (first_fail_got),
      .done           (done),
      .all_pass       (all_pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_of(input int op, input int av, input int bv);
      case (op)
         0: return (av + bv) % 256;
         1: return (av - bv + 256) % 256;
         2: return av & bv;
         3: return av | bv;
         4: return av ^ bv;
         5: return (av * 2) % 256;
         6: return av / 2;
         default: return av;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int tgt);
      start      = 1'b1;
      txn_target = 8'(tgt);
      in_valid   = 1'b0;
      tick();
      start      = 1'b0;
   endtask

   task automatic send(input int op, input int av, input int bv, input int ov);
      op_code  = 3'(op);
      a        = 8'(av);
      b        = 8'(bv);
      alu_out  = 8'(ov);
      in_valid = 1'b1;
      tick();
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_mism"},  32'(mismatch), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_allp"},  32'(all_pass), 32'd0);
      chk({tag, "_pass"},  32'(pass_cnt), 32'd0);
      chk({tag, "_fail"},  32'(fail_cnt), 32'd0);
      chk({tag, "_ffop"},  32'(first_fail_op), 32'd0);
      chk({tag, "_ffexp"}, 32'(first_fail_exp), 32'd0);
      chk({tag, "_ffgot"}, 32'(first_fail_got), 32'd0);
   endtask

   initial begin
      int mism_seen;
      int accepts;
      int vpat[10];
      int ready_late;

      // reset and idle
      tick();
      tick();
      chk_cleared("rst");
      rst = 1'b0;
      in_valid = 1'b1;
      tick();
      tick();
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_pass", 32'(pass_cnt), 32'd0);
      in_valid = 1'b0;

      // 24 correct transactions, back to back
      do_start(24);
      chk("run_ready", 32'(in_ready), 32'd1);
      mism_seen = 0;
      for (int i = 0; i < 24; i++) begin
         send(i % 8, (i * 37 + 5) % 256, (i * 11 + 3) % 256,
              exp_of(i % 8, (i * 37 + 5) % 256, (i * 11 + 3) % 256));
         mism_seen += int'(mismatch);
      end
      in_valid = 1'b0;
      chk("drain_ready", 32'(in_ready), 32'd0);
      chk("drain_done", 32'(done), 32'd0);
      tick();
      chk("r24_done", 32'(done), 32'd1);
      chk("r24_pass", 32'(pass_cnt), 32'd24);
      chk("r24_fail", 32'(fail_cnt), 32'd0);
      chk("r24_allp", 32'(all_pass), 32'd1);
      chk("r24_mism", 32'(mism_seen), 32'd0);

      // first-failure capture and boundary ops
      do_start(5);
      send(0, 8'hF0, 8'h20, 8'h11);
      chk("add_mism", 32'(mismatch), 32'd1);
      send(1, 8'h05, 8'h07, 8'hFE);
      chk("sub_mism", 32'(mismatch), 32'd0);
      chk("ff_op", 32'(first_fail_op), 32'd0);
      chk("ff_exp", 32'(first_fail_exp), 32'h10);
      chk("ff_got", 32'(first_fail_got), 32'h11);
      send(5, 8'h81, 8'h00, 8'h02);
      chk("shl_mism", 32'(mismatch), 32'd0);
      send(6, 8'h81, 8'h00, 8'h40);
      chk("shr_mism", 32'(mismatch), 32'd0);
      send(1, 8'h10, 8'h01, 8'h00);
      chk("sub2_mism", 32'(mismatch), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("ff2_mism", 32'(mismatch), 32'd0);
      chk("ff2_done", 32'(done), 32'd1);
      chk("ff2_pass", 32'(pass_cnt), 32'd3);
      chk("ff2_fail", 32'(fail_cnt), 32'd2);
      chk("ff2_allp", 32'(all_pass), 32'd0);
      chk("ff2_op", 32'(first_fail_op), 32'd0);
      chk("ff2_exp", 32'(first_fail_exp), 32'h10);
      chk("ff2_got", 32'(first_fail_got), 32'h11);

      // gapped in_valid, target 3; unaccepted cycles carry wrong results
      vpat = '{1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
      do_start(3);
      accepts = 0;
      ready_late = 0;
      for (int i = 0; i < 10; i++) begin
         op_code  = 3'd0;
         a        = 8'(i + 1);
         b        = 8'd2;
         alu_out  = (in_ready && vpat[i] == 1) ? 8'(i + 3) : 8'hEE;
         in_valid = (vpat[i] == 1);
         if (in_ready && in_valid) accepts++;
         if (i > 6 && in_ready) ready_late++;
         tick();
      end
      in_valid = 1'b0;
      chk("gap_accepts", 32'(accepts), 32'd3);
      chk("gap_ready_late", 32'(ready_late), 32'd0);
      chk("gap_ready", 32'(in_ready), 32'd0);
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_pass", 32'(pass_cnt), 32'd3);
      chk("gap_fail", 32'(fail_cnt), 32'd0);

      // reset mid-run with a failing compare in flight
      do_start(10);
      send(2, 8'hF0, 8'h3C, 8'h30);
      send(3, 8'hF0, 8'h0F, 8'h00);
      send(4, 8'hAA, 8'hFF, 8'h55);
      send(7, 8'h5A, 8'h00, 8'h5A);
      send(0, 8'h01, 8'h01, 8'h03);
      chk("pre_rst_mism", 32'(mismatch), 32'd1);
      chk("pre_rst_fail", 32'(fail_cnt), 32'd1);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_cleared("mid_rst");
      tick();
      rst = 1'b0;
      #1;
      chk("rel_mism", 32'(mismatch), 32'd0);
      tick();
      chk("rel_mism2", 32'(mismatch), 32'd0);
      chk("rel_ready", 32'(in_ready), 32'd0);
      do_start(1);
      send(4, 8'h0F, 8'hFF, 8'hF0);
      in_valid = 1'b0;
      tick();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_pass", 32'(pass_cnt), 32'd1);
      chk("t1_fail", 32'(fail_cnt), 32'd0);
      chk("t1_allp", 32'(all_pass), 32'd1);

      // start with zero target
      do_start(0);
      chk("t0_done", 32'(done), 32'd1);
      chk("t0_allp", 32'(all_pass), 32'd1);
      chk("t0_pass", 32'(pass_cnt), 32'd0);
      chk("t0_ready", 32'(in_ready), 32'd0);

      // abort: restart while a failing compare is in flight
      do_start(4);
      send(0, 8'h01, 8'h02, 8'h00);
      send(0, 8'h01, 8'h02, 8'h00);
      chk("abort_mism", 32'(mismatch), 32'd1);
      start = 1'b1;
      txn_target = 8'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      chk("abort_fail", 32'(fail_cnt), 32'd0);
      chk("abort_ffexp", 32'(first_fail_exp), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      tick();
      chk("abort_fail2", 32'(fail_cnt), 32'd0);
      send(1, 8'h00, 8'h01, 8'hFF);
      send(2, 8'hC3, 8'h0F, 8'h03);
      in_valid = 1'b0;
      tick();
      chk("abort_done", 32'(done), 32'd1);
      chk("abort_pass", 32'(pass_cnt), 32'd2);

      // failure flood: 300 wrong results offered to a 255-transaction run
      do_start(255);
      for (int i = 0; i < 300; i++) begin
         send(7, i % 256, 0, (i + 1) % 256);
      end
      in_valid = 1'b0;
      tick();
      chk("sat_fail", 32'(fail_cnt), 32'd255);
      chk("sat_pass", 32'(pass_cnt), 32'd0);
      chk("sat_done", 32'(done), 32'd1);
      chk("sat_allp", 32'(all_pass), 32'd0);
      chk("sat_ffop", 32'(first_fail_op), 32'd7);
      chk("sat_ffgot", 32'(first_fail_got), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter TXN_W, default 8, width of transaction counters.
REQ-002 Parameter OPC_W, default 3, width of op_code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; arms a check run.
REQ-006 txn_target  input  TXN_W  transactions to check in this run; sampled on start.
REQ-007 in_valid  input  1  a/b/op_code/alu_out hold one ALU transaction.
REQ-008 in_ready  output  1  checker can accept a transaction.
REQ-009 a, b  input  8 each  ALU operands.
REQ-010 op_code  input  OPC_W  ALU operation.
REQ-011 alu_out  input  8  result produced by the ALU under test.
REQ-012 mismatch  output  1  one-cycle pulse per failing transaction.
REQ-013 pass_cnt, fail_cnt  output  TXN_W each  run counters.
REQ-014 first_fail_op  output  OPC_W; first_fail_exp, first_fail_got  output  8 each  capture of first failure.
REQ-015 done  output  1  run complete, held until next start; all_pass  output  1  valid while done.

Function
REQ-016 Expected result, 8-bit, carry/overflow discarded: 0 ADD a+b, 1 SUB a-b (mod 256), 2 AND, 3 OR, 4 XOR, 5 SHL a<<1, 6 SHR a>>1 logical, 7 PASS a.
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE/DONE -> RUN on start with txn_target != 0; start with txn_target == 0 -> DONE directly, all_pass=1, counters 0.
REQ-019 On start: pass_cnt, fail_cnt, accepted-count cleared; first_fail_* cleared to 0; done cleared.
REQ-020 in_ready = 1 only in RUN; transaction accepted on cycle with in_valid && in_ready.
REQ-021 Accepted transaction registered into a single-stage compare register; comparison result one cycle after acceptance (latency 1).
REQ-022 Back-to-back acceptance every cycle supported; no bubbles required.
REQ-023 RUN -> DRAIN on the cycle the txn_target-th transaction is accepted; in_ready=0 from next cycle.
REQ-024 DRAIN -> DONE after the last compare completes (exactly one cycle); done=1 from DONE entry.
REQ-025 Match: pass_cnt += 1. Mismatch: fail_cnt += 1, mismatch pulses one cycle aligned with the compare.
REQ-026 first_fail_* written only on the first mismatch of a run; later mismatches do not overwrite.
REQ-027 pass_cnt and fail_cnt saturate at all-ones; no wrap.
REQ-028 all_pass = (fail_cnt == 0) while done; 0 otherwise.
REQ-029 start during RUN/DRAIN: aborts run, in-flight compare discarded, counters cleared, re-arms with new txn_target.
REQ-030 in_valid outside RUN ignored; no counter change.
REQ-031 Inputs on unaccepted cycles have no effect; a/b/op_code/alu_out sampled only at acceptance.

Reset
REQ-032 rst asserted: state IDLE, in_ready=0, mismatch=0, done=0, all_pass=0, all counters and first_fail_* = 0, compare register invalid.
REQ-033 rst mid-run: run abandoned immediately; no pulse on mismatch during or on release.
REQ-034 After rst release, no activity until start.

Structure
REQ-035 Package alu_pkg holds opcode enum (ADD..PASS, values 0..7), OPC_W and data-width constant 8; shared with the ALU.
REQ-036 Sub-module alu_ref_model: purely combinational expected-result function of a, b, op_code, instantiated once.
REQ-037 FSM, compare register and counters live in alu_result_checker.

Verification
REQ-038 start, txn_target=24; drive 3 rounds of op 0..7 with correct results, in_valid constant -> done 1 cycle after last accept, pass_cnt=24, fail_cnt=0, all_pass=1.
REQ-039 a=0xF0, b=0x20, op=0 ADD, alu_out=0x11 -> mismatch pulse, first_fail_op=0, exp=0x10, got=0x11; later failure (op=1) leaves capture unchanged.
REQ-040 SUB a=0x05, b=0x07 expecting 0xFE; SHL a=0x81 expecting 0x02; SHR a=0x81 expecting 0x40 -> all pass.
REQ-041 txn_target=3, in_valid toggling with gaps -> exactly 3 accepted, in_ready=0 in DRAIN/DONE, extra in_valid ignored.
REQ-042 Assert rst mid-run after 5 transactions (2 failing) -> all outputs 0 immediately; new start, target=1 -> fresh counts.
REQ-043 start with txn_target=0 -> DONE next cycle, all_pass=1; fail_cnt saturation run with TXN_W=8, 300 failures -> fail_cnt=255.
